alu_issue_ctrl: RTL

- Initiator side of the registered 32-bit ALU interface.
- Accepts tagged operation requests (opcode, two operands) over a valid/ready handshake and drives the ALU's operand and control inputs from registers.
- Tracks the ALU's one-cycle register latency, captures alu_out and zero_flag, and returns in-order tagged responses through a credit-protected response FIFO.
- Sits between an instruction/test sequencer and the ALU; the ALU shares clk and clear.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_rsp_fifo.sv | 69 ++++++
 rtl/alu_issue_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and widths shared by the ALU issue controller.
// Contents: OP_W/DATA_W/OP_LAST widths, opcode localparams, op_is_err helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package alu_pkg;

  localparam int OP_W    = 4;
  localparam int DATA_W  = 32;
  localparam int OP_LAST = 9;

  localparam logic [OP_W-1:0] ADD                = 4'd0;
  localparam logic [OP_W-1:0] SUB                = 4'd1;
  localparam logic [OP_W-1:0] AND                = 4'd2;
  localparam logic [OP_W-1:0] OR                 = 4'd3;
  localparam logic [OP_W-1:0] XOR                = 4'd4;
  localparam logic [OP_W-1:0] LOGICAL_LS         = 4'd5;
  localparam logic [OP_W-1:0] LOGICAL_RS         = 4'd6;
  localparam logic [OP_W-1:0] ARITHMETIC_RS      = 4'd7;
  localparam logic [OP_W-1:0] LESS_THAN_UNSIGNED = 4'd8;
  localparam logic [OP_W-1:0] LESS_THAN_SIGNED   = 4'd9;

  // Opcodes past the last defined one are still issued, but flagged.
  function automatic logic op_is_err(input logic [OP_W-1:0] op);
    return op > OP_W'(OP_LAST);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous FIFO holding packed {err, zero, tag, data} responses.
// Ports: clk/clear, push_i/push_dat_i, pop_i/pop_dat_o, empty_o, count_o.
// Latency: a push is visible on pop_dat_o/!empty_o the next cycle (no bypass).
// Backpressure: push while full is accepted only together with a pop.
module alu_rsp_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           pop_dat_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a push when a pop frees the slot in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator for a registered 32-bit ALU; issues tagged ops, returns in-order tagged responses.
// Latency: accept to rsp_valid is 3 cycles with an empty response FIFO; one accept per cycle sustained.
// Backpressure: req_ready is a credit check (S1 + S2 + FIFO count < RSP_DEPTH); the pipeline itself never stalls.
// Ports: clk/clear; req_valid/req_ready/req_op/req_a/req_b/req_tag; alu_in0/alu_in1/control_signal to the ALU;
//        alu_out/zero_flag from the ALU; rsp_valid/rsp_ready/rsp_data/rsp_zero/rsp_err/rsp_tag.
// Optional: define ALU_ISSUE_STATS_EN to add saturating stat_ops / stat_zero push counters.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  output logic [OP_W-1:0]   control_signal,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              zero_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [31:0]       stat_zero
`endif
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int ENT_W = 1 + 1 + TAG_W + DATA_W;

  // Drive registers feeding the ALU.
  logic [DATA_W-1:0] alu_in0_q, alu_in0_d;
  logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
  logic [OP_W-1:0]   ctrl_q, ctrl_d;

  // S1: operands sit in the drive registers. S2: ALU result register is loaded.
  logic              s1_vld_q, s1_vld_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic              s1_err_q, s1_err_d;
  logic              s2_vld_q, s2_vld_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
  logic              s2_err_q, s2_err_d;

  logic              accept;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  in_flight;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [ENT_W-1:0]  fifo_push_dat;
  logic [ENT_W-1:0]  fifo_pop_dat;

  // Every op in S1/S2 already owns a FIFO slot, so the FIFO can never overflow.
  assign in_flight = CNT_W'(s1_vld_q) + CNT_W'(s2_vld_q) + fifo_cnt;
  assign req_ready = ~clear & (in_flight < CNT_W'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;

  always_comb begin
    alu_in0_d = alu_in0_q;
    alu_in1_d = alu_in1_q;
    ctrl_d    = ctrl_q;
    s1_tag_d  = s1_tag_q;
    s1_err_d  = s1_err_q;
    s1_vld_d  = accept;
    s2_vld_d  = s1_vld_q;
    s2_tag_d  = s1_tag_q;
    s2_err_d  = s1_err_q;
    if (accept) begin
      alu_in0_d = req_a;
      alu_in1_d = req_b;
      ctrl_d    = req_op;
      s1_tag_d  = req_tag;
      s1_err_d  = op_is_err(req_op);
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      alu_in0_q <= '0;
      alu_in1_q <= '0;
      ctrl_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_tag_q  <= '0;
      s1_err_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_tag_q  <= '0;
      s2_err_q  <= 1'b0;
    end else begin
      alu_in0_q <= alu_in0_d;
      alu_in1_q <= alu_in1_d;
      ctrl_q    <= ctrl_d;
      s1_vld_q  <= s1_vld_d;
      s1_tag_q  <= s1_tag_d;
      s1_err_q  <= s1_err_d;
      s2_vld_q  <= s2_vld_d;
      s2_tag_q  <= s2_tag_d;
      s2_err_q  <= s2_err_d;
    end
  end

  assign alu_in0        = alu_in0_q;
  assign alu_in1        = alu_in1_q;
  assign control_signal = ctrl_q;

  // In S2 the ALU result register holds this op's result, so capture it now.
  assign fifo_push_dat = {s2_err_q, zero_flag, s2_tag_q, alu_out};
  assign fifo_pop      = rsp_valid & rsp_ready;

  alu_rsp_fifo #(
    .W     (ENT_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .clear      (clear),
    .push_i     (s2_vld_q),
    .push_dat_i (fifo_push_dat),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_pop_dat),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  // Response fields read zero whenever nothing is presented, including after clear.
  assign rsp_valid = ~fifo_empty;
  assign rsp_data  = rsp_valid ? fifo_pop_dat[DATA_W-1:0]             : '0;
  assign rsp_tag   = rsp_valid ? fifo_pop_dat[DATA_W +: TAG_W]         : '0;
  assign rsp_zero  = rsp_valid ? fifo_pop_dat[DATA_W + TAG_W]          : 1'b0;
  assign rsp_err   = rsp_valid ? fifo_pop_dat[DATA_W + TAG_W + 1]      : 1'b0;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_ops_q;
  logic [31:0] stat_zero_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      stat_ops_q  <= '0;
      stat_zero_q <= '0;
    end else if (s2_vld_q) begin
      if (stat_ops_q != '1)              stat_ops_q  <= stat_ops_q + 1'b1;
      if (zero_flag && stat_zero_q != '1) stat_zero_q <= stat_zero_q + 1'b1;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_zero = stat_zero_q;
`endif

endmodule
